// File: rtl/qoi_ram_ctrl.sv
// qoi_ram_ctrl: two-requester front-end for the QOI synchronous SRAM.
//   Port A (pixel/index-table engine) and port B (6502 bridge) share one SRAM
//   through a round-robin arbiter. Only one transaction is in flight at a time.
//   Writes take one SRAM cycle (WR). Reads take RD_ADDR then RD_DATA, with the
//   read data returned on the originating port three cycles after accept.
//   Out-of-range addresses (>= DEPTH) never reach the SRAM; such reads return 0.
// Optional feature (macro QOI_RAM_CTRL_FWD_EN):
//   A one-entry last-write register answers matching reads in one cycle
//   without touching the SRAM.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   {a,b}_req_valid/ready       request handshake (ready is combinational)
//   {a,b}_req_we/addr/wdata     request payload (1=write)
//   {a,b}_rsp_valid/data        one-cycle read response strobe + held data
//   ram_addr/data/cs/we/oe      SRAM pin interface (ram_data bidirectional)
module qoi_ram_ctrl #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_we,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [7:0]        a_req_wdata,
  output logic              a_rsp_valid,
  output logic [7:0]        a_rsp_data,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_we,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [7:0]        b_req_wdata,
  output logic              b_rsp_valid,
  output logic [7:0]        b_rsp_data,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [7:0]        ram_data,
  output logic              ram_cs,
  output logic              ram_we,
  output logic              ram_oe
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR      = 2'd1;
  localparam logic [1:0] RD_ADDR = 2'd2;
  localparam logic [1:0] RD_DATA = 2'd3;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              rr_q, rr_d;
  logic              port_q, port_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              drive_q, drive_d;
  logic              ram_cs_d, ram_we_d, ram_oe_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic              a_rsp_valid_d, b_rsp_valid_d;
  logic [7:0]        a_rsp_data_d, b_rsp_data_d;

  logic              grant_a, grant_b, accept;
  logic              sel_port, sel_we, in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;
  logic              fwd_hit;
  logic [7:0]        fwd_data;
  logic              rsp_fire, rsp_port;
  logic [7:0]        rsp_byte;

  // Write data goes onto the shared bus only during the WR cycle.
  assign ram_data = drive_q ? wdata_q : {8{1'bz}};

  // Round-robin grant; rr_q only matters when both ports contend.
  always_comb begin
    grant_a     = a_req_valid && (!b_req_valid || (rr_q == PORT_A));
    grant_b     = b_req_valid && (!a_req_valid || (rr_q == PORT_B));
    a_req_ready = (state_q == IDLE) && grant_a;
    b_req_ready = (state_q == IDLE) && grant_b;
    accept      = a_req_ready || b_req_ready;
    sel_port    = b_req_ready ? PORT_B : PORT_A;
    sel_we      = b_req_ready ? b_req_we    : a_req_we;
    sel_addr    = b_req_ready ? b_req_addr  : a_req_addr;
    sel_wdata   = b_req_ready ? b_req_wdata : a_req_wdata;
    in_range    = sel_addr < ADDR_W'(DEPTH);
  end

`ifdef QOI_RAM_CTRL_FWD_EN
  logic              fwd_valid_q;
  logic [ADDR_W-1:0] fwd_addr_q;
  logic [7:0]        fwd_data_q;
  logic              fwd_load;

  assign fwd_load = accept && sel_we && in_range;
  assign fwd_hit  = fwd_valid_q && (fwd_addr_q == sel_addr);
  assign fwd_data = fwd_data_q;

  // Last-write register, refreshed by every in-range write accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= 8'h00;
    end else if (fwd_load) begin
      fwd_valid_q <= 1'b1;
      fwd_addr_q  <= sel_addr;
      fwd_data_q  <= sel_wdata;
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = 8'h00;
`endif

  // Next state; SRAM strobes are computed for the upcoming state and registered.
  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    port_d        = port_q;
    wdata_d       = wdata_q;
    drive_d       = 1'b0;
    ram_cs_d      = 1'b0;
    ram_we_d      = 1'b0;
    ram_oe_d      = 1'b0;
    ram_addr_d    = ram_addr;
    rsp_fire      = 1'b0;
    rsp_port      = port_q;
    rsp_byte      = 8'h00;
    a_rsp_valid_d = 1'b0;
    b_rsp_valid_d = 1'b0;
    a_rsp_data_d  = a_rsp_data;
    b_rsp_data_d  = b_rsp_data;

    case (state_q)
      IDLE: begin
        if (accept) begin
          port_d = sel_port;
          if (a_req_valid && b_req_valid) rr_d = ~sel_port;
          if (!in_range) begin
            // No SRAM cycle; reads complete immediately with zero data.
            rsp_fire = !sel_we;
            rsp_port = sel_port;
            rsp_byte = 8'h00;
          end else if (sel_we) begin
            state_d    = WR;
            ram_cs_d   = 1'b1;
            ram_we_d   = 1'b1;
            drive_d    = 1'b1;
            ram_addr_d = sel_addr;
            wdata_d    = sel_wdata;
          end else if (fwd_hit) begin
            rsp_fire = 1'b1;
            rsp_port = sel_port;
            rsp_byte = fwd_data;
          end else begin
            state_d    = RD_ADDR;
            ram_cs_d   = 1'b1;
            ram_addr_d = sel_addr;
          end
        end
      end
      WR: begin
        state_d = IDLE;
      end
      RD_ADDR: begin
        state_d  = RD_DATA;
        ram_cs_d = 1'b1;
        ram_oe_d = 1'b1;
      end
      RD_DATA: begin
        // SRAM drives the bus this cycle; capture at the closing edge.
        state_d  = IDLE;
        rsp_fire = 1'b1;
        rsp_port = port_q;
        rsp_byte = ram_data;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rsp_fire) begin
      if (rsp_port == PORT_A) begin
        a_rsp_valid_d = 1'b1;
        a_rsp_data_d  = rsp_byte;
      end else begin
        b_rsp_valid_d = 1'b1;
        b_rsp_data_d  = rsp_byte;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= PORT_A;
      port_q      <= PORT_A;
      wdata_q     <= 8'h00;
      drive_q     <= 1'b0;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
      ram_addr    <= '0;
      a_rsp_valid <= 1'b0;
      b_rsp_valid <= 1'b0;
      a_rsp_data  <= 8'h00;
      b_rsp_data  <= 8'h00;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      port_q      <= port_d;
      wdata_q     <= wdata_d;
      drive_q     <= drive_d;
      ram_cs      <= ram_cs_d;
      ram_we      <= ram_we_d;
      ram_oe      <= ram_oe_d;
      ram_addr    <= ram_addr_d;
      a_rsp_valid <= a_rsp_valid_d;
      b_rsp_valid <= b_rsp_valid_d;
      a_rsp_data  <= a_rsp_data_d;
      b_rsp_data  <= b_rsp_data_d;
    end
  end

endmodule

// File: tb/tb_qoi_ram_ctrl.sv
// Self-checking bench for qoi_ram_ctrl with a behavioural registered-read SRAM.
// Build with +define+QOI_RAM_CTRL_FWD_EN to exercise the last-write forwarding.
`timescale 1ns/1ps
module tb_qoi_ram_ctrl;

  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned ADDR_W = 16;
`ifdef QOI_RAM_CTRL_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int RD_LAT_HIT = FWD ? 1 : 3;
  localparam bit CS_HIT     = FWD ? 1'b0 : 1'b1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
  logic [ADDR_W-1:0] a_req_addr;
  logic [7:0]        a_req_wdata, a_rsp_data;
  logic              b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
  logic [ADDR_W-1:0] b_req_addr;
  logic [7:0]        b_req_wdata, b_rsp_data;
  logic [ADDR_W-1:0] ram_addr;
  wire  [7:0]        ram_data;
  logic              ram_cs, ram_we, ram_oe;

  always #5 clk = ~clk;

  qoi_ram_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe)
  );

  // Synchronous SRAM: write on cs&we, registered read on cs&!we, output on oe.
  logic [7:0] mem [0:1023];
  logic [7:0] sram_q;
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end else if (ram_cs) begin
      if (ram_we) mem[ram_addr[9:0]] <= ram_data;
      else        sram_q <= mem[ram_addr[9:0]];
    end
  end
  assign ram_data = (ram_cs && ram_oe && !ram_we) ? sram_q : 8'hzz;

  logic [7:0] model [0:1023];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = 8'h00;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = 8'h00;
  endtask

  task automatic do_reset(input bit clr);
    idle_inputs();
    rst_n    = 1'b0;
    mem_init = clr;
    if (clr) for (int i = 0; i < 1024; i++) model[i] = 8'(i) ^ 8'hA5;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    rst_n    = 1'b1;
  endtask

  // Present a request and return in the cycle it is accepted (bounded).
  task automatic do_req(input bit p, input bit we, input logic [15:0] addr, input logic [7:0] wd);
    int n = 0;
    @(negedge clk);
    if (!p) begin a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd; end
    else    begin b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd; end
    #1;
    while (!(p ? b_req_ready : a_req_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("req_accepted", 32'(n < 20), 32'd1);
  endtask

  // Count cycles from accept to rsp_valid on port p (gives up after 10).
  task automatic wait_rsp(input bit p, output int lat, output logic [7:0] data, output logic cs1);
    lat = 0; cs1 = 1'b0;
    do begin
      @(negedge clk);
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      #1;
      lat++;
      if (lat == 1) cs1 = ram_cs;
    end while (!(p ? b_rsp_valid : a_rsp_valid) && lat < 10);
    data = p ? b_rsp_data : a_rsp_data;
  endtask

  typedef struct {
    logic        a_v, a_we; logic [15:0] a_addr; logic [7:0] a_wd;
    logic        b_v, b_we; logic [15:0] b_addr; logic [7:0] b_wd;
    logic        x_ardy, x_brdy, x_arsp, x_brsp;
    logic [7:0]  x_adata, x_bdata;
    logic        x_cs, x_we, x_oe;
  } vec_t;
  localparam int NV = 16;
  vec_t vec [NV];

  initial begin
    int lat;
    logic [7:0] d;
    logic c1;

    // Cycle-by-cycle vectors starting from reset (rr_ptr = A).
    //          A: v we addr     wd     B: v we addr     wd     rdy a b rsp a b  adata  bdata  cs we oe
    vec[0]  = '{1,1,16'h03FF,8'hC3, 1,1,16'h0005,8'h11, 1,0,0,0, 8'h00,8'h00, 0,0,0};
    vec[1]  = '{0,0,16'h0000,8'h00, 1,1,16'h0005,8'h11, 0,0,0,0, 8'h00,8'h00, 1,1,0};
    vec[2]  = '{0,0,16'h0000,8'h00, 1,1,16'h0005,8'h11, 0,1,0,0, 8'h00,8'h00, 0,0,0};
    vec[3]  = '{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,0,0, 8'h00,8'h00, 1,1,0};
    vec[4]  = '{0,0,16'h0000,8'h00, 1,0,16'h03FF,8'h00, 0,1,0,0, 8'h00,8'h00, 0,0,0};
    vec[5]  = '{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,0,0, 8'h00,8'h00, 1,0,0};
    vec[6]  = '{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,0,0, 8'h00,8'h00, 1,0,1};
    vec[7]  = '{1,0,16'h03FF,8'h00, 0,0,16'h0000,8'h00, 1,0,0,1, 8'h00,8'hC3, 0,0,0};
    vec[8]  = '{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,0,0, 8'h00,8'hC3, 1,0,0};
    vec[9]  = '{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,0,0, 8'h00,8'hC3, 1,0,1};
    vec[10] = '{1,0,16'h0400,8'h00, 0,0,16'h0000,8'h00, 1,0,1,0, 8'hC3,8'hC3, 0,0,0};
    vec[11] = '{0,0,16'h0000,8'h00, 1,1,16'h0400,8'hEE, 0,1,1,0, 8'h00,8'hC3, 0,0,0};
    vec[12] = '{0,0,16'h0000,8'h00, 1,0,16'h0000,8'h00, 0,1,0,0, 8'h00,8'hC3, 0,0,0};
    vec[13] = '{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,0,0, 8'h00,8'hC3, 1,0,0};
    vec[14] = '{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,0,0, 8'h00,8'hC3, 1,0,1};
    vec[15] = '{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0,0,1, 8'h00,8'hA5, 0,0,0};

    // Reset state.
    do_reset(1'b1);
    #1;
    chk("rst_cs", 32'(ram_cs), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_oe", 32'(ram_oe), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);
    chk("rst_a_rsp_data", 32'(a_rsp_data), 32'd0);
    chk("rst_b_rsp_data", 32'(b_rsp_data), 32'd0);

    // Table: A write/B read of 0x3FF, contention, out-of-range, 0x000 untouched.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_req_valid = vec[i].a_v; a_req_we = vec[i].a_we;
      a_req_addr  = vec[i].a_addr; a_req_wdata = vec[i].a_wd;
      b_req_valid = vec[i].b_v; b_req_we = vec[i].b_we;
      b_req_addr  = vec[i].b_addr; b_req_wdata = vec[i].b_wd;
      #1;
      chk($sformatf("vec%0d_a_ready", i), 32'(a_req_ready), 32'(vec[i].x_ardy));
      chk($sformatf("vec%0d_b_ready", i), 32'(b_req_ready), 32'(vec[i].x_brdy));
      chk($sformatf("vec%0d_a_rsp_valid", i), 32'(a_rsp_valid), 32'(vec[i].x_arsp));
      chk($sformatf("vec%0d_b_rsp_valid", i), 32'(b_rsp_valid), 32'(vec[i].x_brsp));
      chk($sformatf("vec%0d_a_rsp_data", i), 32'(a_rsp_data), 32'(vec[i].x_adata));
      chk($sformatf("vec%0d_b_rsp_data", i), 32'(b_rsp_data), 32'(vec[i].x_bdata));
      chk($sformatf("vec%0d_cs", i), 32'(ram_cs), 32'(vec[i].x_cs));
      chk($sformatf("vec%0d_we", i), 32'(ram_we), 32'(vec[i].x_we));
      chk($sformatf("vec%0d_oe", i), 32'(ram_oe), 32'(vec[i].x_oe));
    end
    idle_inputs();

    // Reset asserted during RD_DATA: bus quiet, response dropped.
    do_req(1'b0, 1'b0, 16'h0123, 8'h00);
    @(negedge clk); a_req_valid = 1'b0;
    @(negedge clk); #1;
    chk("rstmid_oe_before", 32'(ram_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_cs", 32'(ram_cs), 32'd0);
    chk("rstmid_we", 32'(ram_we), 32'd0);
    chk("rstmid_oe", 32'(ram_oe), 32'd0);
    chk("rstmid_a_rsp", 32'(a_rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rstmid_no_a_rsp", 32'(a_rsp_valid), 32'd0);
      chk("rstmid_no_b_rsp", 32'(b_rsp_valid), 32'd0);
    end
    do_req(1'b0, 1'b1, 16'h0010, 8'h5A);
    do_req(1'b0, 1'b0, 16'h0010, 8'h00);
    wait_rsp(1'b0, lat, d, c1);
    chk("post_rst_rd_latency", 32'(lat), 32'(RD_LAT_HIT));
    chk("post_rst_rd_data", 32'(d), 32'h5A);

    // Both ports always valid from reset: grants alternate A,B,A,B...
    do_reset(1'b0);
    begin
      int na = 0, nb = 0, n = 0;
      for (int cyc = 0; cyc < 200 && n < 16; cyc++) begin
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 16'h0100 + 16'(na);
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 16'h0200 + 16'(nb);
        #1;
        if (a_req_ready || b_req_ready) begin
          chk("arb_exclusive", 32'(a_req_ready && b_req_ready), 32'd0);
          chk($sformatf("arb_grant%0d", n), 32'(b_req_ready), 32'(n % 2));
          if (a_req_ready) na++; else nb++;
          n++;
        end
      end
      chk("arb_total", 32'(n), 32'd16);
    end
    idle_inputs();
    repeat (4) @(negedge clk);

    // Write then read the same address: forwarded or full SRAM path.
    do_req(1'b1, 1'b1, 16'h0020, 8'h77);
    do_req(1'b1, 1'b0, 16'h0020, 8'h00);
    wait_rsp(1'b1, lat, d, c1);
    chk("fwd_latency", 32'(lat), 32'(RD_LAT_HIT));
    chk("fwd_data", 32'(d), 32'h77);
    chk("fwd_cs", 32'(c1), 32'(CS_HIT));

    // Random traffic on both ports against a scoreboard.
    do_reset(1'b1);
    begin
      bit a_pend = 0, b_pend = 0, exp_pend = 0, exp_port = 0, wchk = 0;
      bit fwd_v = 0;
      logic [15:0] fwd_a = '0, wchk_addr = '0;
      logic [7:0]  fwd_d = '0, exp_data = '0, wchk_data = '0;
      int exp_due = 0, wchk_cyc = 0, acc = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        bit got, p, we, due, in_rng;
        logic [15:0] ad;
        logic [7:0]  wd;
        @(negedge clk);
        if (!a_pend && acc < 200 && $urandom_range(1, 0) == 1) begin
          a_pend = 1; a_req_we = 1'($urandom_range(1, 0)); a_req_wdata = 8'($urandom);
          a_req_addr = ($urandom_range(7, 0) == 0) ? 16'(DEPTH + $urandom_range(15, 0))
                                                    : 16'($urandom_range(15, 0));
        end
        if (!b_pend && acc < 200 && $urandom_range(1, 0) == 1) begin
          b_pend = 1; b_req_we = 1'($urandom_range(1, 0)); b_req_wdata = 8'($urandom);
          b_req_addr = ($urandom_range(7, 0) == 0) ? 16'(DEPTH + $urandom_range(15, 0))
                                                    : 16'($urandom_range(15, 0));
        end
        a_req_valid = a_pend;
        b_req_valid = b_pend;
        #1;
        chk("rnd_we_oe_exclusive", 32'(ram_we && ram_oe), 32'd0);
        due = exp_pend && (cyc == exp_due);
        chk("rnd_a_rsp_valid", 32'(a_rsp_valid), 32'(due && !exp_port));
        chk("rnd_b_rsp_valid", 32'(b_rsp_valid), 32'(due && exp_port));
        if (due) begin
          chk("rnd_rsp_data", 32'(exp_port ? b_rsp_data : a_rsp_data), 32'(exp_data));
          exp_pend = 0;
        end
        if (wchk && cyc == wchk_cyc) begin
          chk("rnd_wr_we", 32'(ram_we), 32'd1);
          chk("rnd_wr_addr", 32'(ram_addr), 32'(wchk_addr));
          chk("rnd_wr_data", 32'(ram_data), 32'(wchk_data));
          wchk = 0;
        end
        got = 0; p = 0; we = 0; ad = '0; wd = '0;
        if (a_req_valid && a_req_ready) begin
          got = 1; p = 0; we = a_req_we; ad = a_req_addr; wd = a_req_wdata; a_pend = 0;
        end else if (b_req_valid && b_req_ready) begin
          got = 1; p = 1; we = b_req_we; ad = b_req_addr; wd = b_req_wdata; b_pend = 0;
        end
        if (got) begin
          acc++;
          in_rng = ad < 16'(DEPTH);
          if (we) begin
            if (in_rng) begin
              model[ad[9:0]] = wd;
              fwd_v = 1; fwd_a = ad; fwd_d = wd;
              wchk = 1; wchk_cyc = cyc + 1; wchk_addr = ad; wchk_data = wd;
            end
          end else begin
            exp_pend = 1; exp_port = p;
            if (!in_rng) begin
              exp_data = 8'h00; exp_due = cyc + 1;
            end else if (FWD && fwd_v && fwd_a == ad) begin
              exp_data = fwd_d; exp_due = cyc + 1;
            end else begin
              exp_data = model[ad[9:0]]; exp_due = cyc + 3;
            end
          end
        end
        if (acc >= 200 && !a_pend && !b_pend && !exp_pend && !wchk) break;
      end
      chk("rnd_all_done", 32'(acc >= 200 && !exp_pend), 32'd1);
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
